// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, function
// codes, ALU / mux select codes, FSM states and the instruction-class vector.
package mc_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001100;
  localparam logic [5:0] OP_LOAD  = 6'b001101;
  localparam logic [5:0] OP_STORE = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b010010;

  // Function codes (IR[5:0]) qualifying the two R-format encodings
  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // ALU operation codes
  localparam logic [2:0] ALUC_ADD = 3'd0;
  localparam logic [2:0] ALUC_SUB = 3'd1;
  localparam logic [2:0] ALUC_XOR = 3'd2;
  localparam logic [2:0] ALUC_SRL = 3'd3;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  // Sequencer states; the encoding is visible on the debug state port
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic rtype_add;
    logic rtype_srl;
    logic addi;
    logic xori;
    logic load;
    logic store;
    logic beq;
    logic j;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/func decoder producing a one-hot instruction class.
// Exactly one bit is set; unknown encodings raise illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass
);

  // Classify the instruction; anything unmatched falls through to illegal
  always_comb begin
    iclass = '0;
    case (op)
      OP_RTYPE: begin
        if (func == FN_ADD) iclass.rtype_add = 1'b1;
        else                iclass.illegal   = 1'b1;
      end
      OP_SRL: begin
        if (func == FN_SRL) iclass.rtype_srl = 1'b1;
        else                iclass.illegal   = 1'b1;
      end
      OP_ADDI:  iclass.addi    = 1'b1;
      OP_XORI:  iclass.xori    = 1'b1;
      OP_LOAD:  iclass.load    = 1'b1;
      OP_STORE: iclass.store   = 1'b1;
      OP_BEQ:   iclass.beq     = 1'b1;
      OP_J:     iclass.j       = 1'b1;
      default:  iclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: steps each instruction through IF/ID/EXE/MEM/WB,
// drives the datapath control strings, waits on the memory handshake, traps
// on illegal instructions and counts retired instructions.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W   = 3,
  parameter int RETIRE_W = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                rsrtequ,
  input  logic                mem_ready,
  output logic                wpc,
  output logic                wir,
  output logic                wmem,
  output logic                wreg,
  output logic                iord,
  output logic                regrt,
  output logic                m2reg,
  output logic                shift,
  output logic                sext,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALUC_W-1:0]   aluc,
  output logic [1:0]          pcsource,
  output logic [2:0]          state,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_reg;
  state_t              state_next;
  logic [RETIRE_W-1:0] retired_reg;
  iclass_t             iclass;
  logic                ready;
  logic                retire;
  logic                wpc_raw;
  logic                wir_raw;
  logic                wmem_raw;
  logic                wreg_raw;
  logic [2:0]          aluc_sel;

  mc_ctrl_decode u_decode (
    .op     (op),
    .func   (func),
    .iclass (iclass)
  );

  // Without wait-state support the memory is assumed to answer every cycle
  assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= S_IF;
    else       state_reg <= state_next;
  end

  // Retired-instruction counter, bumped on the edge leaving an instruction's last state
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       retired_reg <= '0;
    else if (retire) retired_reg <= retired_reg + RETIRE_W'(1);
  end

  // Next-state and control decode; every output starts at 0
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    wpc_raw    = 1'b0;
    wir_raw    = 1'b0;
    wmem_raw   = 1'b0;
    wreg_raw   = 1'b0;
    iord       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    shift      = 1'b0;
    sext       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    aluc_sel   = ALUC_ADD;
    pcsource   = PCSRC_ALU;
    trap       = 1'b0;

    case (state_reg)
      S_IF: begin
        // PC + 4 is computed every cycle; it is only committed once the fetch lands
        alusrcb = SRCB_FOUR;
        if (ready) begin
          wpc_raw    = 1'b1;
          wir_raw    = 1'b1;
          state_next = S_ID;
        end
      end

      S_ID: begin
        // ALU is idle here, so precompute PC + (imm << 2) for a possible branch
        alusrcb = SRCB_IMM_SH;
        sext    = 1'b1;
        if (iclass.j) begin
          pcsource   = PCSRC_JUMP;
          wpc_raw    = 1'b1;
          retire     = 1'b1;
          state_next = S_IF;
        end else if (iclass.illegal) begin
          state_next = S_TRAP;
        end else begin
          state_next = S_EXE;
        end
      end

      S_EXE: begin
        if (iclass.rtype_add) begin
          alusrca    = 1'b1;
          state_next = S_WB;
        end else if (iclass.rtype_srl) begin
          shift      = 1'b1;
          aluc_sel   = ALUC_SRL;
          state_next = S_WB;
        end else if (iclass.addi || iclass.load || iclass.store) begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          sext       = 1'b1;
          state_next = (iclass.addi) ? S_WB : S_MEM;
        end else if (iclass.xori) begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          aluc_sel   = ALUC_XOR;
          state_next = S_WB;
        end else if (iclass.beq) begin
          // Compare via SUB; the target computed in ID is taken only when equal
          alusrca    = 1'b1;
          aluc_sel   = ALUC_SUB;
          pcsource   = PCSRC_BRANCH;
          wpc_raw    = rsrtequ;
          retire     = 1'b1;
          state_next = S_IF;
        end else begin
          state_next = S_TRAP;
        end
      end

      S_MEM: begin
        iord = 1'b1;
        if (iclass.store) begin
          wmem_raw = 1'b1;
          if (ready) begin
            retire     = 1'b1;
            state_next = S_IF;
          end
        end else if (ready) begin
          state_next = S_WB;
        end
      end

      S_WB: begin
        // Immediate extension mode is held from EXE so the written result stays consistent
        wreg_raw   = 1'b1;
        regrt      = iclass.addi | iclass.xori | iclass.load;
        m2reg      = iclass.load;
        sext       = iclass.addi | iclass.load;
        retire     = 1'b1;
        state_next = S_IF;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_next = S_IF;
      end
    endcase
  end

  // Architectural write strobes are held off for the whole time reset is high
  assign wpc  = wpc_raw  & ~reset;
  assign wir  = wir_raw  & ~reset;
  assign wmem = wmem_raw & ~reset;
  assign wreg = wreg_raw & ~reset;

  assign aluc    = ALUC_W'(aluc_sel);
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: each instruction is expanded by a
// schedule model into its expected per-cycle state and control strings, which
// are compared against the unit cycle by cycle along with the retire count.
module tb_mc_control_unit;

  localparam int RW = 4;

  // instruction classes known to the model
  localparam int C_ADD = 0, C_SRL = 1, C_ADDI = 2, C_XORI = 3, C_LOAD = 4;
  localparam int C_STORE = 5, C_BEQ = 6, C_J = 7, C_ILL = 8;

  typedef struct packed {
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluc;
    logic [1:0] pcsource;
    logic       trap;
  } ctl_t;

  // rdy: 0 drive mem_ready low, 1 drive high, 2 don't care (random)
  typedef struct {
    logic [2:0] st;
    ctl_t       ctl;
    int         rdy;
    bit         ret;
  } cyc_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    op = '0, func = '0;
  logic          rsrtequ = 1'b0, mem_ready = 1'b1;
  logic          wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, sext, alusrca, trap;
  logic [1:0]    alusrcb, pcsource;
  logic [2:0]    aluc, state;
  logic [RW-1:0] retired;

  int            total = 0;
  int            bad = 0;
  logic [RW-1:0] model_ret = '0;
  cyc_t          q[$];

  mc_control_unit #(.ALUC_W(3), .RETIRE_W(RW), .MEM_WAIT(1)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .rsrtequ(rsrtequ),
    .mem_ready(mem_ready), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg),
    .iord(iord), .regrt(regrt), .m2reg(m2reg), .shift(shift), .sext(sext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
    .state(state), .trap(trap), .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    return ctl_t'({wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, sext, alusrca,
                   alusrcb, aluc, pcsource, trap});
  endfunction

  function automatic void push(input logic [2:0] st, input ctl_t c, input int rdy, input bit ret);
    cyc_t r;
    r.st = st; r.ctl = c; r.rdy = rdy; r.ret = ret;
    q.push_back(r);
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t c = '0;
    c.alusrcb = 2'b01;
    return c;
  endfunction

  function automatic logic [5:0] op_of(input int cls);
    case (cls)
      C_ADD:   return 6'b000000;
      C_SRL:   return 6'b000010;
      C_ADDI:  return 6'b000101;
      C_XORI:  return 6'b001100;
      C_LOAD:  return 6'b001101;
      C_STORE: return 6'b001110;
      C_BEQ:   return 6'b001111;
      default: return 6'b010010;
    endcase
  endfunction

  function automatic logic [5:0] func_of(input int cls);
    if (cls == C_ADD) return 6'b000001;
    if (cls == C_SRL) return 6'b000010;
    return 6'($urandom);
  endfunction

  // Expected cycle-by-cycle schedule of one instruction
  function automatic void build(input int cls, input int if_w, input int mem_w, input bit eq);
    ctl_t c;
    bool_ls: begin end
    q.delete();
    for (int i = 0; i < if_w; i++) push(3'd0, fetch_ctl(), 0, 1'b0);
    c = fetch_ctl(); c.wpc = 1'b1; c.wir = 1'b1;
    push(3'd0, c, 1, 1'b0);
    // decode: branch target precompute, jumps finish here
    c = '0; c.alusrcb = 2'b11; c.sext = 1'b1;
    if (cls == C_J) begin c.wpc = 1'b1; c.pcsource = 2'b11; end
    push(3'd1, c, 2, cls == C_J);
    if (cls == C_J || cls == C_ILL) return;
    c = '0;
    case (cls)
      C_ADD:   c.alusrca = 1'b1;
      C_SRL:   begin c.shift = 1'b1; c.aluc = 3'd3; end
      C_XORI:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluc = 3'd2; end
      C_BEQ:   begin c.alusrca = 1'b1; c.aluc = 3'd1; c.pcsource = 2'b01; c.wpc = eq; end
      default: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.sext = 1'b1; end
    endcase
    push(3'd2, c, 2, cls == C_BEQ);
    if (cls == C_BEQ) return;
    if (cls == C_LOAD || cls == C_STORE) begin
      c = '0; c.iord = 1'b1; c.wmem = (cls == C_STORE);
      for (int i = 0; i < mem_w; i++) push(3'd3, c, 0, 1'b0);
      push(3'd3, c, 1, cls == C_STORE);
      if (cls == C_STORE) return;
    end
    c = '0; c.wreg = 1'b1;
    c.regrt = (cls == C_ADDI || cls == C_XORI || cls == C_LOAD);
    c.m2reg = (cls == C_LOAD);
    c.sext  = (cls == C_ADDI || cls == C_LOAD);
    push(3'd4, c, 2, 1'b1);
  endfunction

  // Play the schedule against the DUT; stop_at < 0 runs it to completion
  task automatic run(input string name, input logic [5:0] opv, input logic [5:0] fnv,
                     input bit eq, input bit post, input int stop_at);
    int n = 0;
    foreach (q[i]) begin
      @(negedge clock);
      if (q[i].st == 3'd0) begin op = 6'($urandom); func = 6'($urandom); end
      else begin op = opv; func = fnv; end
      rsrtequ = (q[i].st == 3'd2) ? eq : 1'($urandom);
      case (q[i].rdy)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'($urandom);
      endcase
      #2;
      check({name, "/state"}, 32'(state), 32'(q[i].st));
      check({name, "/ctl"}, 32'(obs()), 32'(q[i].ctl));
      if (q[i].ret) model_ret = model_ret + 1'b1;
      n++;
      if (i == stop_at) break;
    end
    if (post) begin
      @(posedge clock); #1;
      check({name, "/end_state"}, 32'(state), 32'd0);
      check({name, "/retired"}, 32'(retired), 32'(model_ret));
    end
    $display("instr %-10s op=%b func=%b cycles=%0d retired_model=%0d", name, opv, fnv, n, model_ret);
  endtask

  task automatic do_reset(input string name);
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; op = 6'($urandom); func = 6'($urandom);
    #2;
    model_ret = '0;
    check({name, "/state"}, 32'(state), 32'd0);
    check({name, "/ctl"}, 32'(obs()), 32'(fetch_ctl()));
    check({name, "/retired"}, 32'(retired), 32'(model_ret));
    @(posedge clock); #1;
    check({name, "/hold_state"}, 32'(state), 32'd0);
    check({name, "/hold_wir"}, 32'(wir), 32'd0);
    reset = 1'b0;
    $display("reset %s", name);
  endtask

  task automatic run_class(input string name, input int cls, input int if_w, input int mem_w, input bit eq);
    logic [5:0] o, f;
    o = op_of(cls); f = func_of(cls);
    build(cls, if_w, mem_w, eq);
    run(name, o, f, eq, 1'b1, -1);
  endtask

  task automatic run_illegal(input string name, input logic [5:0] o, input logic [5:0] f);
    ctl_t c = '0;
    c.trap = 1'b1;
    build(C_ILL, int'($urandom_range(0, 2)), 0, 1'b0);
    for (int i = 0; i < 20; i++) push(3'd5, c, 2, 1'b0);
    run(name, o, f, 1'b0, 1'b0, -1);
    check({name, "/retired"}, 32'(retired), 32'(model_ret));
    do_reset({name, "_rst"});
  endtask

  initial begin
    logic [5:0] o, f;
    int cls;

    do_reset("por");

    // directed instruction shapes
    run_class("addi", C_ADDI, 0, 0, 1'b0);
    run_class("load", C_LOAD, 2, 3, 1'b0);
    run_class("beq_eq", C_BEQ, 0, 0, 1'b1);
    run_class("beq_ne", C_BEQ, 0, 0, 1'b0);
    run_class("j", C_J, 0, 0, 1'b0);
    run_class("srl", C_SRL, 0, 0, 1'b0);
    run_class("add", C_ADD, 1, 0, 1'b0);
    run_class("xori", C_XORI, 0, 0, 1'b0);
    run_class("store", C_STORE, 1, 2, 1'b0);

    // random legal instruction stream; > 16 retirements so the counter wraps
    for (int k = 0; k < 40; k++) begin
      cls = int'($urandom_range(0, 7));
      run_class("rand", cls, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), 1'($urandom));
    end

    // reset while a store is waiting in MEM: write strobe drops at once, nothing retires
    build(C_STORE, 0, 3, 1'b0);
    run("store_rst", op_of(C_STORE), 6'($urandom), 1'b0, 1'b0, 3);
    check("store_rst/ret_before", 32'(retired), 32'(model_ret));
    #1 reset = 1'b1;
    #1;
    model_ret = '0;
    check("store_rst/wmem", 32'(wmem), 32'd0);
    check("store_rst/state", 32'(state), 32'd0);
    check("store_rst/retired", 32'(retired), 32'(model_ret));
    @(posedge clock); #1 reset = 1'b0;
    $display("reset store_rst");

    run_class("post_rst", C_ADDI, 0, 0, 1'b0);

    // illegal encodings
    run_illegal("ill_op3f", 6'b111111, 6'($urandom));
    run_illegal("ill_rfunc", 6'b000000, 6'b000011);
    run_illegal("ill_srlfn", 6'b000010, 6'b000001);
    do begin
      o = 6'($urandom);
    end while (o inside {6'd0, 6'd2, 6'd5, 6'd12, 6'd13, 6'd14, 6'd15, 6'd18});
    f = 6'($urandom);
    run_illegal("ill_rand", o, f);

    run_class("final", C_LOAD, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
